// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline writeback always
// wins; multi-cycle (mul/div) results bypass when the port is free or wait in
// a small circular FIFO. Exports a scoreboard of registers with results still
// outstanding.
module writeback_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter int REG_COUNT   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         RegWriteW,
  input  logic [$clog2(REG_COUNT)-1:0] RdW,
  input  logic [DATA_WIDTH-1:0]        ResultW,
  input  logic                         MDIssue,
  input  logic [$clog2(REG_COUNT)-1:0] MDIssueRd,
  input  logic                         MDValid,
  input  logic [$clog2(REG_COUNT)-1:0] MDRd,
  input  logic [DATA_WIDTH-1:0]        MDResult,
  output logic                         MDReady,
  output logic                         RegWriteOut,
  output logic [$clog2(REG_COUNT)-1:0] RdOut,
  output logic [DATA_WIDTH-1:0]        WDOut,
  output logic [REG_COUNT-1:0]         PendingMask,
  output logic                         WawErr
);
  localparam int RW = $clog2(REG_COUNT);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [RW-1:0]         q_rd   [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  logic live, pop, push, bypass, md_write;
  logic [REG_COUNT-1:0] set_mask, clr_mask;

  // x0 writes never occupy the port
  assign live = RegWriteW && (RdW != '0);

  // Readiness comes from the registered count only, so a same-cycle pop never
  // opens a slot combinationally.
  assign MDReady = !reset && (count < CW'(QUEUE_DEPTH));

  // Port select: pipeline, then FIFO head, then MD bypass; all zero in reset
  always_comb begin
    RegWriteOut = 1'b0;
    RdOut       = '0;
    WDOut       = '0;
    pop         = 1'b0;
    bypass      = 1'b0;
    md_write    = 1'b0;
    if (!reset) begin
      if (live) begin
        RegWriteOut = 1'b1;
        RdOut       = RdW;
        WDOut       = ResultW;
      end else if (count != '0) begin
        RegWriteOut = 1'b1;
        RdOut       = q_rd[rd_ptr];
        WDOut       = q_data[rd_ptr];
        pop         = 1'b1;
        md_write    = 1'b1;
      end else if (MDValid && (MDRd != '0)) begin
        RegWriteOut = 1'b1;
        RdOut       = MDRd;
        WDOut       = MDResult;
        bypass      = 1'b1;
        md_write    = 1'b1;
      end
    end
  end

  // Accepted non-x0 results that did not bypass go to the tail; x0 results drop
  assign push = MDValid && MDReady && (MDRd != '0) && !bypass;

  // Diagnostic only: the hazard unit is expected to prevent this
  assign WawErr = !reset && live && PendingMask[RdW];

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap freely
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless once count says empty
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= MDRd;
      q_data[wr_ptr] <= MDResult;
    end
  end

  // Scoreboard set/clear masks; a set to the same register overrides a clear
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (MDIssue && (MDIssueRd != '0)) set_mask[MDIssueRd] = 1'b1;
    if (md_write)                     clr_mask[RdOut]     = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) PendingMask <= '0;
    else       PendingMask <= (PendingMask & ~clr_mask) | set_mask;
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: the stimulus side runs a queue-based
// reference model and pushes expected port values; a monitor pops and compares.
module tb_writeback_arbiter;
  localparam int DW = 32;
  localparam int QD = 2;

  logic          clk, reset;
  logic          RegWriteW, MDIssue, MDValid;
  logic [4:0]    RdW, MDIssueRd, MDRd;
  logic [DW-1:0] ResultW, MDResult;
  logic          MDReady, RegWriteOut, WawErr;
  logic [4:0]    RdOut;
  logic [DW-1:0] WDOut;
  logic [31:0]   PendingMask;

  writeback_arbiter #(.DATA_WIDTH(DW), .QUEUE_DEPTH(QD), .REG_COUNT(32)) dut (
    .clk(clk), .reset(reset),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .MDIssue(MDIssue), .MDIssueRd(MDIssueRd),
    .MDValid(MDValid), .MDRd(MDRd), .MDResult(MDResult), .MDReady(MDReady),
    .RegWriteOut(RegWriteOut), .RdOut(RdOut), .WDOut(WDOut),
    .PendingMask(PendingMask), .WawErr(WawErr)
  );

  typedef struct packed {
    logic          we;
    logic [4:0]    rd;
    logic [DW-1:0] wd;
    logic          rdy;
    logic          waw;
    logic [31:0]   pend;
  } exp_t;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } ent_t;

  exp_t  exp_q[$];
  string name_q[$];
  ent_t  mq[$];         // model FIFO contents, head at index 0
  bit    mpend[32];     // model scoreboard
  int    checks = 0;
  int    errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle: drive at negedge, predict this cycle's outputs, advance model
  task automatic step(input string nm, input logic rst,
                      input logic rw, input logic [4:0] rd, input logic [DW-1:0] res,
                      input logic iss, input logic [4:0] ird,
                      input logic mv, input logic [4:0] mrd, input logic [DW-1:0] mres);
    exp_t e;
    ent_t ent;
    bit   is_live, ready, byp, mdw;
    logic [4:0] clr_rd;
    @(negedge clk);
    reset = rst; RegWriteW = rw; RdW = rd; ResultW = res;
    MDIssue = iss; MDIssueRd = ird; MDValid = mv; MDRd = mrd; MDResult = mres;
    e = '0;
    if (rst) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 0;
    end else begin
      for (int i = 0; i < 32; i++) e.pend[i] = mpend[i];
      is_live = rw && rd != 0;
      ready   = mq.size() < QD;
      e.rdy   = ready;
      e.waw   = is_live && mpend[rd];
      byp = 0; mdw = 0; clr_rd = 0;
      if (is_live) begin
        e.we = 1; e.rd = rd; e.wd = res;
      end else if (mq.size() > 0) begin
        ent = mq.pop_front();
        e.we = 1; e.rd = ent.rd; e.wd = ent.data;
        mdw = 1; clr_rd = ent.rd;
      end else if (mv && mrd != 0) begin
        e.we = 1; e.rd = mrd; e.wd = mres;
        byp = 1; mdw = 1; clr_rd = mrd;
      end
      if (mv && ready && mrd != 0 && !byp) mq.push_back('{rd: mrd, data: mres});
      if (mdw) mpend[clr_rd] = 0;
      if (iss && ird != 0) mpend[ird] = 1;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input string nm);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT port against the oldest prediction
  always @(negedge clk) begin
    exp_t  e, a;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {RegWriteOut, RdOut, WDOut, MDReady, WawErr, PendingMask};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got we=%0b rd=%0d wd=%h rdy=%0b waw=%0b pend=%h, want we=%0b rd=%0d wd=%h rdy=%0b waw=%0b pend=%h",
                 nm, a.we, a.rd, a.wd, a.rdy, a.waw, a.pend,
                 e.we, e.rd, e.wd, e.rdy, e.waw, e.pend);
      end
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1; RegWriteW = 0; RdW = 0; ResultW = 0; MDIssue = 0; MDIssueRd = 0;
    MDValid = 0; MDRd = 0; MDResult = 0;
    foreach (mpend[i]) mpend[i] = 0;

    step("reset", 1, 1, 3, 32'h11, 1, 4, 1, 5, 32'h22);
    idle("post_reset");

    // Bypass
    step("issue_x5", 0, 0, 0, 0, 1, 5, 0, 0, 0);
    step("bypass_x5", 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234);
    idle("bypass_clear");

    // Conflict queueing
    step("conflict", 0, 1, 3, 32'hAA, 0, 0, 1, 7, 32'hBB);
    idle("drain_x7");
    idle("empty_after_x7");

    // Full FIFO
    step("fill_x8", 0, 1, 1, 32'h1, 0, 0, 1, 8, 32'h8);
    step("fill_x9", 0, 1, 2, 32'h2, 0, 0, 1, 9, 32'h9);
    step("full_x10", 0, 1, 3, 32'h3, 0, 0, 1, 10, 32'hA);
    step("drain_x8", 0, 0, 0, 0, 0, 0, 1, 10, 32'hA);
    step("drain_x9", 0, 0, 0, 0, 0, 0, 1, 10, 32'hA);
    idle("drain_x10");
    idle("empty_after_x10");

    // x0 handling
    step("x0_pipe_bypass", 0, 1, 0, 32'h99, 0, 0, 1, 4, 32'h55);
    step("x0_issue", 0, 0, 0, 0, 1, 0, 1, 0, 32'h77);
    idle("x0_after");

    // Scoreboard race and WAW
    step("issue_x6", 0, 0, 0, 0, 1, 6, 0, 0, 0);
    step("race_x6", 0, 0, 0, 0, 1, 6, 1, 6, 32'h66);
    step("waw_x6", 0, 1, 6, 32'h60, 0, 0, 0, 0, 0);
    step("clear_x6", 0, 0, 0, 0, 0, 0, 1, 6, 32'h61);
    idle("after_x6");

    // Reset mid-queue
    step("issue_x7", 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step("issue_x8", 0, 0, 0, 0, 1, 8, 0, 0, 0);
    step("q_x7", 0, 1, 1, 32'h1, 0, 0, 1, 7, 32'h77);
    step("q_x8", 0, 1, 2, 32'h2, 0, 0, 1, 8, 32'h88);
    step("mid_reset", 1, 1, 3, 32'h33, 1, 9, 1, 9, 32'h99);
    idle("no_stale_write");
    idle("after_reset");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic rw, iss, mv;
      rw  = ($urandom_range(0, 99) < 50);
      iss = ($urandom_range(0, 99) < 25);
      mv  = ($urandom_range(0, 99) < 45);
      step("random", ($urandom_range(0, 199) == 0),
           rw, 5'($urandom_range(0, 31)), $urandom(),
           iss, 5'($urandom_range(0, 31)),
           mv, 5'($urandom_range(0, 31)), $urandom());
    end
    idle("final");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    #3;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d predictions left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
